// File: rtl/obstacle_scheduler_if.sv
// Bus between the menu/collision logic (master) and the obstacle scheduler (slave).
// Also carries the shared selected/play_selected lines seen by the obstacle modules.
interface obstacle_scheduler_if;
  logic        game_start;
  logic        menu_on;
  logic        game_over;
  logic [15:0] done_in;
  logic [3:0]  selected;
  logic        play_selected;
  logic [7:0]  cleared;
  logic        victory;
  logic        defeat;
  logic        timeout_pulse;
  logic        busy;

  modport master (
    output game_start, menu_on, game_over, done_in,
    input  selected, play_selected, cleared, victory, defeat, timeout_pulse, busy
  );

  modport slave (
    input  game_start, menu_on, game_over, done_in,
    output selected, play_selected, cleared, victory, defeat, timeout_pulse, busy
  );
endinterface

// File: rtl/obstacle_scheduler.sv
// Game sequencer: draws obstacle codes from an LFSR, runs each obstacle with a
// blank gap in between, counts clears and ends the game on win, collision or menu.
module obstacle_scheduler #(
  parameter int         NUM_OBSTACLES  = 4,
  parameter int         GAP_CYCLES     = 32500000,
  parameter int         ROUNDS_TO_WIN  = 8,
  parameter int         TIMEOUT_CYCLES = 390000000,
  parameter logic [7:0] LFSR_SEED      = 8'hA5
) (
  input  logic                 pclk,
  input  logic                 rst,
  obstacle_scheduler_if.slave  bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_GAP  = 2'd1;
  localparam logic [1:0] S_PLAY = 2'd2;
  localparam logic [1:0] S_END  = 2'd3;

  localparam logic [31:0] GAP_LAST = 32'(GAP_CYCLES - 1);
  localparam logic [31:0] TO_LAST  = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]  WIN_CNT  = 8'(ROUNDS_TO_WIN);
  localparam logic [4:0]  NUM_CODE = 5'(NUM_OBSTACLES);

  logic [1:0]  state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [7:0]  lfsr_q, lfsr_d;
  logic [3:0]  selected_q, selected_d;
  logic [3:0]  prev_q, prev_d;
  logic [7:0]  cleared_q, cleared_d;
  logic        victory_q, victory_d;
  logic        defeat_q, defeat_d;
  logic        timeout_q, timeout_d;
  logic        play_q, play_d;
  logic        busy_q, busy_d;
  logic [3:0]  draw;
  logic [7:0]  cleared_inc;
  logic        done_hit;

  // Skip the previous code so the same obstacle never runs twice in a row.
  function automatic logic [3:0] draw_code(input logic [7:0] lfsr, input logic [3:0] prev);
    logic [4:0] cand;
    cand = {1'b0, lfsr[3:0]} % NUM_CODE;
    if (cand[3:0] == prev) cand = (cand + 5'd1) % NUM_CODE;
    return cand[3:0];
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign draw        = draw_code(lfsr_q, prev_q);
  assign cleared_inc = sat_inc(cleared_q);
  assign done_hit    = bus.done_in[selected_q];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    selected_d = selected_q;
    prev_d     = prev_q;
    cleared_d  = cleared_q;
    victory_d  = victory_q;
    defeat_d   = defeat_q;
    timeout_d  = 1'b0;
    lfsr_d     = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    if (bus.menu_on) begin
      state_d   = S_IDLE;
      victory_d = 1'b0;
      defeat_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_END: begin
          if (bus.game_start) begin
            state_d   = S_GAP;
            cnt_d     = '0;
            cleared_d = '0;
            victory_d = 1'b0;
            defeat_d  = 1'b0;
          end
        end
        S_GAP: begin
          if (bus.game_over) begin
            state_d  = S_END;
            defeat_d = 1'b1;
          end else if (cnt_q == GAP_LAST) begin
            state_d    = S_PLAY;
            selected_d = draw;
            prev_d     = draw;
            cnt_d      = '0;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
        S_PLAY: begin
          // Collision beats completion, completion beats the watchdog.
          if (bus.game_over) begin
            state_d  = S_END;
            defeat_d = 1'b1;
          end else if (done_hit) begin
            cleared_d = cleared_inc;
            cnt_d     = '0;
            if (cleared_inc == WIN_CNT) begin
              state_d   = S_END;
              victory_d = 1'b1;
            end else begin
              state_d = S_GAP;
            end
          end else if (cnt_q == TO_LAST) begin
            state_d   = S_GAP;
            timeout_d = 1'b1;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    play_d = (state_d == S_PLAY);
    busy_d = (state_d == S_GAP) || (state_d == S_PLAY);
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      lfsr_q     <= LFSR_SEED;
      selected_q <= '0;
      prev_q     <= 4'hF;
      cleared_q  <= '0;
      victory_q  <= 1'b0;
      defeat_q   <= 1'b0;
      timeout_q  <= 1'b0;
      play_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lfsr_q     <= lfsr_d;
      selected_q <= selected_d;
      prev_q     <= prev_d;
      cleared_q  <= cleared_d;
      victory_q  <= victory_d;
      defeat_q   <= defeat_d;
      timeout_q  <= timeout_d;
      play_q     <= play_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.selected      = selected_q;
  assign bus.play_selected = play_q;
  assign bus.cleared       = cleared_q;
  assign bus.victory       = victory_q;
  assign bus.defeat        = defeat_q;
  assign bus.timeout_pulse = timeout_q;
  assign bus.busy          = busy_q;

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Directed bench for obstacle_scheduler with short gap, timeout and win count.
module tb_obstacle_scheduler;
  logic pclk = 1'b0;
  logic rst  = 1'b1;
  always #5 pclk = ~pclk;

  obstacle_scheduler_if bus();

  obstacle_scheduler #(
    .NUM_OBSTACLES(4), .GAP_CYCLES(4), .ROUNDS_TO_WIN(3),
    .TIMEOUT_CYCLES(10), .LFSR_SEED(8'hA5)
  ) dut (
    .pclk(pclk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] m_lfsr, m_lfsr_prev;
  logic [3:0] m_prev = 4'hF;
  logic [3:0] exp_sel, last_sel;

  // Reference LFSR: 8-bit Fibonacci, taps 8,6,5,4, shifting every cycle.
  always @(posedge pclk) begin
    m_lfsr_prev <= m_lfsr;
    m_lfsr      <= rst ? 8'hA5 : {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  function automatic logic [3:0] ref_draw(input logic [7:0] l, input logic [3:0] p);
    logic [3:0] c;
    c = l[3:0] % 4'd4;
    if (c == p) c = (c + 4'd1) % 4'd4;
    return c;
  endfunction

  task automatic tick();
    @(negedge pclk);
  endtask

  // Waits (bounded) for the next PLAY entry and returns the model's expected code.
  task automatic wait_play(input string tag, output logic [3:0] code);
    int n;
    n = 0;
    while (bus.play_selected !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (bus.play_selected !== 1'b1) begin
      errors++;
      $display("FAIL %s_wait_play: play_selected=%b after %0d cycles, required 1", tag, bus.play_selected, n);
    end
    code   = ref_draw(m_lfsr_prev, m_prev);
    m_prev = code;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.game_start = 1'b0; bus.menu_on = 1'b0; bus.game_over = 1'b0; bus.done_in = '0;
    tick(); tick();
    checks++;
    if ({bus.selected, bus.play_selected, bus.cleared, bus.victory, bus.defeat,
         bus.timeout_pulse, bus.busy} !== 18'd0) begin
      errors++;
      $display("FAIL reset_outputs: sel=%h play=%b clr=%0d vic=%b def=%b to=%b busy=%b, required all 0",
               bus.selected, bus.play_selected, bus.cleared, bus.victory, bus.defeat, bus.timeout_pulse, bus.busy);
    end
    checks++;
    if (dut.lfsr_q !== 8'hA5) begin errors++; $display("FAIL reset_lfsr: got %h required a5", dut.lfsr_q); end
    rst = 1'b0;
  endtask

  task automatic test_start();
    bus.game_start = 1'b1; tick(); bus.game_start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1 || bus.play_selected !== 1'b0 || bus.cleared !== 8'd0) begin
      errors++;
      $display("FAIL start_gap: busy=%b play=%b clr=%0d, required 1 0 0", bus.busy, bus.play_selected, bus.cleared);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.play_selected !== 1'b0) begin errors++; $display("FAIL start_gap_play%0d: got %b required 0", i, bus.play_selected); end
    end
    tick();
    checks++;
    if (bus.play_selected !== 1'b1) begin errors++; $display("FAIL start_play_rise: got %b required 1", bus.play_selected); end
    exp_sel = ref_draw(m_lfsr_prev, m_prev);
    m_prev  = exp_sel;
    checks++;
    if (bus.selected !== exp_sel) begin errors++; $display("FAIL start_selected: got %0d required %0d", bus.selected, exp_sel); end
  endtask

  task automatic test_done();
    int low;
    last_sel = bus.selected;
    bus.done_in = 16'h1 << ((last_sel + 4'd1) % 4'd4); tick(); bus.done_in = '0;
    checks++;
    if (bus.play_selected !== 1'b1 || bus.cleared !== 8'd0) begin
      errors++;
      $display("FAIL done_other_bit: play=%b clr=%0d, required 1 0", bus.play_selected, bus.cleared);
    end
    bus.done_in = 16'h1 << last_sel; tick(); bus.done_in = '0;
    checks++;
    if (bus.cleared !== 8'd1 || bus.play_selected !== 1'b0 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL done_clear: clr=%0d play=%b busy=%b, required 1 0 1", bus.cleared, bus.play_selected, bus.busy);
    end
    low = 1;
    tick();
    while (bus.play_selected !== 1'b1 && low < 40) begin low++; tick(); end
    checks++;
    if (low != 4) begin errors++; $display("FAIL done_gap_len: low for %0d cycles, required 4", low); end
    exp_sel = ref_draw(m_lfsr_prev, m_prev);
    m_prev  = exp_sel;
    checks++;
    if (bus.selected !== exp_sel || bus.selected === last_sel) begin
      errors++;
      $display("FAIL done_next_sel: got %0d required %0d (previous %0d)", bus.selected, exp_sel, last_sel);
    end
  endtask

  task automatic test_win();
    bus.done_in = 16'h1 << bus.selected; tick(); bus.done_in = '0;
    checks++;
    if (bus.cleared !== 8'd2 || bus.busy !== 1'b1) begin
      errors++; $display("FAIL win_second: clr=%0d busy=%b, required 2 1", bus.cleared, bus.busy);
    end
    wait_play("win", exp_sel);
    bus.done_in = 16'h1 << bus.selected; tick(); bus.done_in = '0;
    checks++;
    if (bus.victory !== 1'b1 || bus.defeat !== 1'b0 || bus.cleared !== 8'd3 || bus.busy !== 1'b0 || bus.play_selected !== 1'b0) begin
      errors++;
      $display("FAIL win_end: vic=%b def=%b clr=%0d busy=%b play=%b, required 1 0 3 0 0",
               bus.victory, bus.defeat, bus.cleared, bus.busy, bus.play_selected);
    end
    tick(); tick();
    checks++;
    if (bus.victory !== 1'b1 || bus.cleared !== 8'd3) begin
      errors++; $display("FAIL win_hold: vic=%b clr=%0d, required 1 3", bus.victory, bus.cleared);
    end
    bus.game_start = 1'b1; tick(); bus.game_start = 1'b0;
    checks++;
    if (bus.cleared !== 8'd0 || bus.victory !== 1'b0 || bus.busy !== 1'b1) begin
      errors++; $display("FAIL win_restart: clr=%0d vic=%b busy=%b, required 0 0 1", bus.cleared, bus.victory, bus.busy);
    end
  endtask

  task automatic test_collision();
    wait_play("coll", exp_sel);
    bus.done_in = 16'h1 << bus.selected; bus.game_over = 1'b1; tick();
    bus.done_in = '0; bus.game_over = 1'b0;
    checks++;
    if (bus.defeat !== 1'b1 || bus.victory !== 1'b0 || bus.cleared !== 8'd0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL collision_priority: def=%b vic=%b clr=%0d busy=%b, required 1 0 0 0",
               bus.defeat, bus.victory, bus.cleared, bus.busy);
    end
  endtask

  task automatic test_timeout();
    int bad;
    bus.game_start = 1'b1; tick(); bus.game_start = 1'b0;
    wait_play("to_a", exp_sel);
    bus.done_in = 16'h1 << bus.selected; tick(); bus.done_in = '0;
    wait_play("to_b", exp_sel);
    bad = 0;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (bus.timeout_pulse !== 1'b0 || bus.play_selected !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL timeout_early: %0d early cycles, required 0", bad); end
    tick();
    checks++;
    if (bus.timeout_pulse !== 1'b1 || bus.play_selected !== 1'b0 || bus.busy !== 1'b1 || bus.cleared !== 8'd1) begin
      errors++;
      $display("FAIL timeout_fire: to=%b play=%b busy=%b clr=%0d, required 1 0 1 1",
               bus.timeout_pulse, bus.play_selected, bus.busy, bus.cleared);
    end
    tick();
    checks++;
    if (bus.timeout_pulse !== 1'b0) begin errors++; $display("FAIL timeout_width: got %b required 0", bus.timeout_pulse); end
  endtask

  task automatic test_menu_abort();
    wait_play("menu", exp_sel);
    bus.menu_on = 1'b1; bus.done_in = 16'h1 << bus.selected; tick();
    bus.done_in = '0;
    checks++;
    if (bus.play_selected !== 1'b0 || bus.busy !== 1'b0 || bus.cleared !== 8'd1 ||
        bus.victory !== 1'b0 || bus.defeat !== 1'b0) begin
      errors++;
      $display("FAIL menu_abort: play=%b busy=%b clr=%0d vic=%b def=%b, required 0 0 1 0 0",
               bus.play_selected, bus.busy, bus.cleared, bus.victory, bus.defeat);
    end
    bus.game_start = 1'b1; tick(); bus.game_start = 1'b0;
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL menu_blocks_start: busy=%b required 0", bus.busy); end
    bus.menu_on = 1'b0;
  endtask

  task automatic test_rst_mid_gap();
    bus.game_start = 1'b1; tick(); bus.game_start = 1'b0;
    tick();
    rst = 1'b1; tick();
    checks++;
    if ({bus.selected, bus.play_selected, bus.cleared, bus.victory, bus.defeat,
         bus.timeout_pulse, bus.busy} !== 18'd0 || dut.lfsr_q !== 8'hA5) begin
      errors++;
      $display("FAIL rst_mid_gap: sel=%h play=%b clr=%0d busy=%b lfsr=%h, required 0 0 0 0 a5",
               bus.selected, bus.play_selected, bus.cleared, bus.busy, dut.lfsr_q);
    end
    rst = 1'b0;
    m_prev = 4'hF;
  endtask

  initial begin
    test_reset();
    test_start();
    test_done();
    test_win();
    test_collision();
    test_timeout();
    test_menu_abort();
    test_rst_mid_gap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
